// File: rtl/prog_counter_ctrl.sv
// prog_counter_ctrl: program counter sequencer with start/done handshake and saturating cycle counter
module prog_counter_ctrl #(
    parameter int PC_W  = 10,
    parameter int CYC_W = 16
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             start,
    input  logic [PC_W-1:0]  start_addr,
    input  logic             halt,
    input  logic             jump,
    input  logic [PC_W-1:0]  jump_target,
    input  logic             branch_en,
    output logic [PC_W-1:0]  PC,
    output logic             fetch_en,
    output logic             done,
    output logic [CYC_W-1:0] cycle_count
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
    state_t state, state_n;
    logic [PC_W-1:0] pc_n;
    logic [CYC_W-1:0] cnt_n, cnt_inc;
    logic done_n, armed;
    assign fetch_en = state == RUN;
    assign cnt_inc = &cycle_count ? cycle_count : cycle_count + 1'b1;
    // armed remembers start from the previous edge, so only a real falling start launches a run
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            PC          <= '0;
            done        <= 1'b0;
            cycle_count <= '0;
            armed       <= 1'b0;
        end else begin
            state       <= state_n;
            PC          <= pc_n;
            done        <= done_n;
            cycle_count <= cnt_n;
            armed       <= start;
        end
    end
    always_comb begin
        state_n = state;
        pc_n    = PC;
        cnt_n   = cycle_count;
        done_n  = done;
        if (start) begin
            state_n = IDLE;
            pc_n    = start_addr;
            cnt_n   = '0;
            done_n  = 1'b0;
        end else begin
            case (state)
                IDLE: state_n = armed ? RUN : IDLE;
                RUN: begin
                    cnt_n = cnt_inc;
                    if (fetch_en && halt) begin
                        state_n = HALTED;
                        done_n  = 1'b1;
                    end else if (fetch_en && jump) begin
                        pc_n = jump_target;
                    end else begin
                        pc_n = PC + ((fetch_en && branch_en) ? PC_W'(2) : PC_W'(1));
                    end
                end
                default: state_n = state;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_counter_ctrl.sv
// tb_prog_counter_ctrl: directed plus randomized check of prog_counter_ctrl against a rule-level model
module tb_prog_counter_ctrl;
    logic       CLK = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] start_addr = '0;
    logic       halt = 1'b0;
    logic       jump = 1'b0;
    logic [9:0] jump_target = '0;
    logic       branch_en = 1'b0;
    logic [9:0] PC, pc4;
    logic       fetch_en, done, fetch4, done4;
    logic [15:0] cycle_count;
    logic [3:0]  cnt4;
    int n_tests = 0;
    int n_fail = 0;

    prog_counter_ctrl #(.PC_W(10), .CYC_W(16)) dut (
        .CLK(CLK), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .halt(halt), .jump(jump), .jump_target(jump_target), .branch_en(branch_en),
        .PC(PC), .fetch_en(fetch_en), .done(done), .cycle_count(cycle_count));

    prog_counter_ctrl #(.PC_W(10), .CYC_W(4)) dut4 (
        .CLK(CLK), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .halt(halt), .jump(jump), .jump_target(jump_target), .branch_en(branch_en),
        .PC(pc4), .fetch_en(fetch4), .done(done4), .cycle_count(cnt4));

    always #5 CLK = ~CLK;

    // rule-level model: running/halted flags, integer PC mod 1024, unbounded cycle count
    bit m_run = 0, m_halted = 0, m_done = 0, m_prev_start = 0;
    int m_pc = 0, m_cnt = 0;

    always @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            m_run = 0; m_halted = 0; m_done = 0; m_prev_start = 0; m_pc = 0; m_cnt = 0;
        end else begin
            if (start) begin
                m_pc = int'(start_addr); m_cnt = 0; m_done = 0; m_run = 0; m_halted = 0;
            end else if (m_run) begin
                m_cnt = m_cnt + 1;
                if (halt) begin
                    m_run = 0; m_halted = 1; m_done = 1;
                end else if (jump) m_pc = int'(jump_target);
                else m_pc = (m_pc + (branch_en ? 2 : 1)) % 1024;
            end else if (!m_halted && m_prev_start) m_run = 1;
            m_prev_start = start;
        end
    end

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        check("model_pc", int'(PC), m_pc);
        check("model_fetch_en", int'(fetch_en), int'(m_run));
        check("model_done", int'(done), int'(m_done));
        check("model_cnt16", int'(cycle_count), m_cnt > 65535 ? 65535 : m_cnt);
        check("model_cnt4", int'(cnt4), m_cnt > 15 ? 15 : m_cnt);
        check("model_pc4", int'(pc4), m_pc);
    end

    task automatic cyc(int n = 1);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    initial begin
        cyc(2);
        reset_n = 1'b1;
        cyc(3);
        check("idle_no_start_pc", int'(PC), 0);
        check("idle_no_start_fetch", int'(fetch_en), 0);
        start = 1'b1; start_addr = 10'd5;
        cyc(3);
        start = 1'b0;
        check("load_pc", int'(PC), 5);
        check("load_fetch", int'(fetch_en), 0);
        cyc();
        check("run0_pc", int'(PC), 5);
        check("run0_fetch", int'(fetch_en), 1);
        check("run0_cnt", int'(cycle_count), 0);
        cyc();
        check("run1_pc", int'(PC), 6);
        check("run1_cnt", int'(cycle_count), 1);
        cyc();
        check("run2_pc", int'(PC), 7);
        check("run2_cnt", int'(cycle_count), 2);
        cyc();
        check("pc8", int'(PC), 8);
        branch_en = 1'b1;
        cyc();
        branch_en = 1'b0;
        check("skip_pc10", int'(PC), 10);
        cyc();
        check("fall_pc11", int'(PC), 11);
        cyc();
        jump = 1'b1; jump_target = 10'd40; branch_en = 1'b1;
        cyc();
        jump = 1'b0; branch_en = 1'b0;
        check("jump_beats_skip", int'(PC), 40);
        start = 1'b1; start_addr = 10'd1022;
        cyc();
        start = 1'b0; branch_en = 1'b1;
        cyc();
        check("wrap_start", int'(PC), 1022);
        cyc();
        check("wrap_skip_0", int'(PC), 0);
        cyc();
        check("wrap_skip_2", int'(PC), 2);
        branch_en = 1'b0; start = 1'b1; start_addr = 10'd1023;
        cyc();
        start = 1'b0;
        cyc();
        check("wrap_max", int'(PC), 1023);
        cyc();
        check("wrap_inc_0", int'(PC), 0);
        start = 1'b1; start_addr = 10'd0;
        cyc();
        start = 1'b0;
        cyc(5);
        check("pre_halt_pc", int'(PC), 4);
        halt = 1'b1; jump = 1'b1; jump_target = 10'd99;
        cyc();
        halt = 1'b0; jump = 1'b0;
        check("halt_done", int'(done), 1);
        check("halt_pc", int'(PC), 4);
        check("halt_fetch", int'(fetch_en), 0);
        check("halt_cnt", int'(cycle_count), 5);
        cyc(10);
        check("halt_hold_pc", int'(PC), 4);
        check("halt_hold_cnt", int'(cycle_count), 5);
        check("halt_hold_done", int'(done), 1);
        start = 1'b1; start_addr = 10'd7;
        cyc();
        start = 1'b0;
        check("restart_done", int'(done), 0);
        check("restart_pc", int'(PC), 7);
        cyc(14);
        check("pc20", int'(PC), 20);
        reset_n = 1'b0;
        #1;
        check("async_pc", int'(PC), 0);
        check("async_fetch", int'(fetch_en), 0);
        check("async_done", int'(done), 0);
        check("async_cnt", int'(cycle_count), 0);
        cyc();
        reset_n = 1'b1;
        cyc(3);
        check("post_reset_idle", int'(fetch_en), 0);
        check("post_reset_pc", int'(PC), 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(21);
        check("sat4", int'(cnt4), 15);
        check("nosat16", int'(cycle_count), 20);
        for (int i = 0; i < 600; i++) begin
            start       = ($urandom_range(0, 19) == 0);
            start_addr  = 10'($urandom);
            halt        = ($urandom_range(0, 29) == 0);
            jump        = ($urandom_range(0, 5) == 0);
            jump_target = 10'($urandom);
            branch_en   = 1'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                reset_n = 1'b0;
                #1;
                reset_n = 1'b1;
            end
            cyc();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
